// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and the parity helper for the queued UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    typedef struct packed {
        logic two_stop;
        logic even_parity;
        logic parity_en;
    } uart_tx_cfg_t;

    localparam int unsigned MAX_DATA_W = 9;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - first-word-fall-through FIFO holding {cfg, data} entries
module uart_tx_queue #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Caller guarantees push only when !full and pop only when !empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - parametrised UART transmitter with per-word config and input queue
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          parity_en,
    input  logic                          even_parity,
    input  logic                          two_stop,
    input  logic                          tx_start,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int QW    = DATA_W + 3;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    logic                 q_push, q_pop, q_full, q_empty;
    logic [QW-1:0]        q_wdata, q_rdata;

    uart_tx_state_e       state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop2_q, stop2_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    uart_tx_cfg_t         cfg_q, cfg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic                 bit_done, load;

    assign q_push  = tx_start && !q_full;
    assign q_wdata = {two_stop, even_parity, parity_en, data_in};

    uart_tx_queue #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .pop_data  (q_rdata),
        .count     (fifo_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // The shift register rotates, so after the last data bit it still holds
    // every data bit and the parity can be taken from it directly.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stop2_d  = stop2_q;
        shift_d  = shift_q;
        cfg_d    = cfg_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        q_pop    = 1'b0;
        load     = 1'b0;
        bit_done = (baud_q == BAUD_LAST);
        baud_d   = bit_done ? '0 : baud_q + 1'b1;
        ovf_d    = tx_start && q_full;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                load   = !q_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {shift_q[0], shift_q[DATA_W-1:1]};
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {shift_q[0], shift_q[DATA_W-1:1]};
                    end else if (cfg_q.parity_en) begin
                        state_d = PARITY;
                        tx_d    = parity_bit(MAX_DATA_W'(shift_q), cfg_q.even_parity);
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        stop2_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (cfg_q.two_stop && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (!q_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            q_pop   = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            baud_d  = '0;
            shift_d = q_rdata[DATA_W-1:0];
            cfg_d   = uart_tx_cfg_t'(q_rdata[QW-1:DATA_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            stop2_q <= 1'b0;
            shift_q <= '0;
            cfg_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            stop2_q <= stop2_d;
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign overflow = ovf_q;
    assign tx_ready = !q_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - directed self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [7:0] d8 = '0;
    logic       pe8 = 0, ev8 = 0, ts2_8 = 0, st8 = 0;
    logic       rdy8, tx8, busy8, ov8;
    logic [2:0] cnt8;

    logic [7:0] d16 = '0;
    logic       pe16 = 0, ev16 = 0, ts2_16 = 0, st16 = 0;
    logic       rdy16, tx16, busy16, ov16;
    logic [2:0] cnt16;

    logic [6:0] d7 = '0;
    logic       pe7 = 0, ev7 = 0, ts2_7 = 0, st7 = 0;
    logic       rdy7, tx7, busy7, ov7;
    logic [2:0] cnt7;

    uart_tx_fifo_param #(.DATA_W(8), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u8 (
        .clk(clk), .rst_n(rst_n), .data_in(d8), .parity_en(pe8), .even_parity(ev8),
        .two_stop(ts2_8), .tx_start(st8), .tx_ready(rdy8), .tx(tx8), .tx_busy(busy8),
        .fifo_count(cnt8), .overflow(ov8));

    uart_tx_fifo_param #(.DATA_W(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u16 (
        .clk(clk), .rst_n(rst_n), .data_in(d16), .parity_en(pe16), .even_parity(ev16),
        .two_stop(ts2_16), .tx_start(st16), .tx_ready(rdy16), .tx(tx16), .tx_busy(busy16),
        .fifo_count(cnt16), .overflow(ov16));

    uart_tx_fifo_param #(.DATA_W(7), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u7 (
        .clk(clk), .rst_n(rst_n), .data_in(d7), .parity_en(pe7), .even_parity(ev7),
        .two_stop(ts2_7), .tx_start(st7), .tx_ready(rdy7), .tx(tx7), .tx_busy(busy7),
        .fifo_count(cnt7), .overflow(ov7));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void get(input int which, output logic t, output logic b);
        case (which)
            0:       begin t = tx8;  b = busy8;  end
            1:       begin t = tx16; b = busy16; end
            default: begin t = tx7;  b = busy7;  end
        endcase
    endfunction

    // Waits (bounded) for tx_busy, then records tx once per clock while busy.
    task automatic collect(input int which, output logic [255:0] bits, output int len);
        logic t, b;
        int   guard;
        bits  = '0;
        len   = 0;
        guard = 0;
        get(which, t, b);
        while (!b && guard < 50) begin
            step();
            get(which, t, b);
            guard++;
        end
        while (b && len < 256) begin
            bits[len] = t;
            len++;
            step();
            get(which, t, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx8: got %b want 1", tx8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b want 1", rdy8); end
        checks++; if (cnt8 !== 3'd0) begin errors++; $display("FAIL reset_count8: got %0d want 0", cnt8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %b want 0", ov8); end
        checks++; if ({tx16, busy16, tx7, busy7} !== 4'b1010) begin
            errors++; $display("FAIL reset_others: got %b want 1010", {tx16, busy16, tx7, busy7});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if ({tx8, busy8, cnt8} !== 5'b10000) begin
            errors++; $display("FAIL post_reset_idle: got %b want 10000", {tx8, busy8, cnt8});
        end
    endtask

    task automatic test_parity_even();
        logic [255:0] bits;
        int len;
        d8 = 8'hA5; pe8 = 1; ev8 = 1; ts2_8 = 0; st8 = 1;
        step();
        st8 = 0; d8 = 8'h00; pe8 = 0; ev8 = 0;
        checks++; if ({busy8, cnt8} !== 4'b0001) begin
            errors++; $display("FAIL t1_latency: got busy=%b cnt=%0d want busy=0 cnt=1", busy8, cnt8);
        end
        collect(0, bits, len);
        checks++; if (len !== 11) begin errors++; $display("FAIL t1_busy_len: got %0d want 11", len); end
        checks++; if (bits[10:0] !== 11'b10101001010) begin
            errors++; $display("FAIL t1_bits: got %b want %b", bits[10:0], 11'b10101001010);
        end
    endtask

    task automatic test_odd_two_stop();
        logic [255:0] bits;
        int len;
        d8 = 8'hFF; pe8 = 1; ev8 = 0; ts2_8 = 1; st8 = 1;
        step();
        st8 = 0; ts2_8 = 0;
        collect(0, bits, len);
        checks++; if (len !== 12) begin errors++; $display("FAIL t2_busy_len: got %0d want 12", len); end
        checks++; if (bits[11:0] !== 12'b111111111110) begin
            errors++; $display("FAIL t2_bits: got %b want %b", bits[11:0], 12'b111111111110);
        end
    endtask

    // First word goes straight to the line, the next four fill the queue, the sixth overflows.
    task automatic test_back_to_back();
        logic [255:0] bits;
        logic [49:0]  want;
        logic         prev_busy;
        int len, falls;
        want = {1'b1, 8'h05, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b0,
                1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
        bits = '0; len = 0; falls = 0; prev_busy = 0;
        pe8 = 0; ev8 = 0; ts2_8 = 0;
        for (int c = 0; c < 60; c++) begin
            st8 = (c < 6);
            d8  = 8'(c + 1);
            step();
            if (busy8) begin bits[len] = tx8; len++; end
            if (prev_busy && !busy8) falls++;
            prev_busy = busy8;
            if (c == 1) begin
                checks++; if (cnt8 !== 3'd1) begin errors++; $display("FAIL t3_push_pop_count: got %0d want 1", cnt8); end
            end
            if (c == 4) begin
                checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL t3_ready_full: got %b want 0", rdy8); end
                checks++; if (cnt8 !== 3'd4) begin errors++; $display("FAIL t3_count_full: got %0d want 4", cnt8); end
                checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL t3_ovf_early: got %b want 0", ov8); end
            end
            if (c == 5) begin
                checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL t3_ovf_pulse: got %b want 1", ov8); end
                checks++; if (cnt8 !== 3'd4) begin errors++; $display("FAIL t3_count_drop: got %0d want 4", cnt8); end
            end
            if (c == 6) begin
                checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL t3_ovf_one_cycle: got %b want 0", ov8); end
            end
        end
        checks++; if (len !== 50) begin errors++; $display("FAIL t3_busy_len: got %0d want 50", len); end
        checks++; if (falls !== 1) begin errors++; $display("FAIL t3_busy_gaps: got %0d falls want 1", falls); end
        checks++; if (bits[49:0] !== want) begin errors++; $display("FAIL t3_bits: got %h want %h", bits[49:0], want); end
        checks++; if (cnt8 !== 3'd0) begin errors++; $display("FAIL t3_drained: got %0d want 0", cnt8); end
    endtask

    task automatic test_baud16();
        logic [255:0] bits;
        logic [9:0]   frame;
        int len, bad;
        frame = 10'b1010101010;
        d16 = 8'h55; pe16 = 0; ts2_16 = 0; st16 = 1;
        step();
        st16 = 0;
        collect(1, bits, len);
        bad = 0;
        for (int i = 0; i < 160; i++) if (bits[i] !== frame[i / 16]) bad++;
        checks++; if (len !== 160) begin errors++; $display("FAIL t4_busy_len: got %0d want 160", len); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL t4_bit_hold: got %0d wrong samples want 0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        logic [255:0] bits;
        int len;
        pe8 = 0; ev8 = 0; ts2_8 = 0;
        d8 = 8'h11; st8 = 1; step();
        d8 = 8'h22; step();
        d8 = 8'h33; step();
        st8 = 0;
        repeat (3) step();
        checks++; if ({busy8, cnt8} !== 4'b1010) begin
            errors++; $display("FAIL t5_pre_reset: got busy=%b cnt=%0d want busy=1 cnt=2", busy8, cnt8);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({tx8, busy8, cnt8, ov8, rdy8} !== 7'b1000001) begin
            errors++; $display("FAIL t5_async_reset: got %b want 1000001", {tx8, busy8, cnt8, ov8, rdy8});
        end
        step();
        checks++; if ({tx8, busy8} !== 2'b10) begin errors++; $display("FAIL t5_held_reset: got %b want 10", {tx8, busy8}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if ({tx8, busy8, cnt8, ov8} !== 6'b100000) begin
            errors++; $display("FAIL t5_post_release: got %b want 100000", {tx8, busy8, cnt8, ov8});
        end
        d8 = 8'h3C; st8 = 1; step();
        st8 = 0;
        collect(0, bits, len);
        checks++; if (len !== 10) begin errors++; $display("FAIL t5_busy_len: got %0d want 10", len); end
        checks++; if (bits[9:0] !== 10'b1001111000) begin
            errors++; $display("FAIL t5_bits: got %b want %b", bits[9:0], 10'b1001111000);
        end
    endtask

    task automatic test_data_w7();
        logic [255:0] bits;
        int len;
        d7 = 7'h41; pe7 = 1; ev7 = 1; ts2_7 = 0; st7 = 1;
        step();
        st7 = 0; d7 = 7'h7F;
        collect(2, bits, len);
        checks++; if (len !== 10) begin errors++; $display("FAIL t6_busy_len: got %0d want 10", len); end
        checks++; if (bits[9:0] !== 10'b1010000010) begin
            errors++; $display("FAIL t6_bits: got %b want %b", bits[9:0], 10'b1010000010);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_parity_even();
        test_odd_two_stop();
        test_back_to_back();
        test_baud16();
        test_reset_mid_frame();
        test_data_w7();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
